// File: rtl/alu_pkg.sv
// Shared ALU opcodes and the writeback entry layout.
// Imported by the writeback stage and its bench.
package alu_pkg;

  localparam int ALU_N  = 16;
  localparam int ALU_RW = 4;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_AND = 3'b001,
    OP_SUB = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_MUL = 3'b101,
    OP_DIV = 3'b110,
    OP_MIN = 3'b111
  } alu_op_t;

  typedef struct packed {
    logic [2*ALU_N-1:0] result;
    alu_op_t            op;
    logic [ALU_RW-1:0]  rd;
    logic               we;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Generic show-ahead FIFO: rdata is the oldest entry while not empty.
// Push is ignored when full, pop when empty; no full-bypass.
module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count
             + (AW+1)'(do_push)
             - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/alu_wb_stage.sv
// ALU writeback stage: buffers results and drains them to the
// register file, tracking HI and the zero/negative flags.
module alu_wb_stage
  import alu_pkg::*;
#(
  parameter int N     = 16,
  parameter int RW    = 4,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2*N-1:0]           in_result,
  input  alu_op_t                  in_op,
  input  logic [RW-1:0]            in_rd,
  input  logic                     in_we,
  output logic                     rf_we,
  output logic [RW-1:0]            rf_waddr,
  output logic [N-1:0]             rf_wdata,
  input  logic                     rf_ready,
  output logic [N-1:0]             hi_out,
  output logic                     flag_z,
  output logic                     flag_n,
  output logic [$clog2(DEPTH):0]   count
);

  typedef struct packed {
    logic [2*N-1:0] result;
    alu_op_t        op;
    logic [RW-1:0]  rd;
    logic           we;
  } entry_t;

  localparam int EW = $bits(entry_t);

  entry_t        in_e;
  entry_t        head;
  logic [EW-1:0] head_raw;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [RW-1:0] last_addr;
  logic [N-1:0]  last_data;

  assign in_e = '{
    result: in_result,
    op:     in_op,
    rd:     in_rd,
    we:     in_we
  };

  assign in_ready = ~full;
  assign push     = in_valid & ~full;
  assign head     = entry_t'(head_raw);
  assign rf_we    = ~empty & head.we;
  // Flags-only entries never wait on the register file.
  assign pop      = ~empty & (rf_ready | ~head.we);

  assign rf_waddr = empty ? last_addr : head.rd;
  assign rf_wdata = empty ? last_data : head.result[N-1:0];

  wb_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (in_e),
    .rdata (head_raw),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_out    <= '0;
      flag_z    <= 1'b1;
      flag_n    <= 1'b0;
      last_addr <= '0;
      last_data <= '0;
    end else if (pop) begin
      flag_z    <= (head.result[N-1:0] == '0);
      flag_n    <= head.result[N-1];
      last_addr <= head.rd;
      last_data <= head.result[N-1:0];
      if (head.op == OP_MUL) hi_out <= head.result[2*N-1:N];
    end
  end

endmodule

// File: doc/alu_wb_stage.md
Name: alu_wb_stage

Overview:
Writeback stage directly downstream of the 16-bit ALU core. It captures each 2N-bit ALU result with its destination tag into a small FIFO, and drains entries to the register-file write port under backpressure. On each writeback it updates the architectural HI register (upper half of multiply results) and the zero/negative flags. It decouples the combinational ALU from a register file that can stall.

Parameters:
N, 16, datapath width; the ALU result is 2N bits
RW, 4, register-address width (2**RW registers)
DEPTH, 2, FIFO entries; must be a power of two and at least 2

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
in_valid  input  1  ALU result on in_result is valid this cycle
in_ready  output  1  stage can accept an entry; equals !full
in_result  input  2N  ALU output
in_op  input  3  ALU operation that produced in_result (alu_pkg encoding)
in_rd  input  RW  destination register
in_we  input  1  the instruction writes rd; 0 means flags-only (compare/branch)
rf_we  output  1  register-file write strobe
rf_waddr  output  RW  write address
rf_wdata  output  N  write data, equal to result[N-1:0]
rf_ready  input  1  register file accepts the write this cycle
hi_out  output  N  HI register
flag_z  output  1  last retired result[N-1:0] == 0
flag_n  output  1  last retired result[N-1]
count  output  $clog2(DEPTH)+1  occupancy, for debug and verification

Behaviour:
- Reset (async assert, sync release): FIFO empty, count=0, in_ready=1, rf_we=0, rf_waddr=0, rf_wdata=0, hi_out=0, flag_z=1, flag_n=0. Reset during operation discards all entries in flight.
- Push: on a rising edge with in_valid & in_ready, write {result, op, rd, we} at wr_ptr. Pointers wrap modulo DEPTH.
- Head entry: the FIFO is show-ahead. When not empty, rf_waddr, rf_wdata and the head fields present the oldest entry combinationally from storage.
- rf_we = !empty & head.we.
- Pop (retire) happens on a rising edge when !empty and either rf_ready=1 or head.we=0. Flags-only entries retire without waiting for rf_ready.
- On retire:
  - flag_z <= (head.result[N-1:0]==0)
  - flag_n <= head.result[N-1]
  - if head.op==OP_MUL, hi_out <= head.result[2N-1:N]; otherwise hi_out is unchanged.
  - Flags and HI update on the same edge the write is accepted.
- Latency: minimum one cycle. A push at edge k is visible on the rf_* ports after edge k and retires at edge k+1 at the earliest. Throughput is one entry per cycle when rf_ready stays high.
- Full: in_ready=0, and a new entry cannot be written even if the head retires that same cycle (no bypass). The upstream holds its data.
- Empty: rf_we=0. rf_waddr and rf_wdata hold their last-driven values and are don't-care to the consumer.
- Simultaneous push and pop when not full: both occur and count is unchanged.
- Upstream must hold in_* stable while in_valid & !in_ready. The bench asserts this; the RTL does not check it.
- Stall: when rf_ready=0 with head.we=1, the head and all rf_* outputs stay stable until acceptance.
- Only bits [N-1:0] are written to the register file. Bits [2N-1:N] are used only for OP_MUL.

Decomposition:
- alu_pkg holds:
  - typedef enum logic[2:0] alu_op_t: OP_ADD=000, OP_AND=001, OP_SUB=010, OP_OR=011, OP_XOR=100, OP_MUL=101, OP_DIV=110, OP_MIN=111
  - a packed struct wb_entry_t {result, op, rd, we}, parameterised through N and RW localparams
- Sub-module wb_fifo: a generic show-ahead synchronous FIFO with DEPTH, a width parameter, push/pop inputs and full/empty/count outputs. alu_wb_stage instantiates it and adds the retire, HI and flag logic.

Test Plan:
- Reset check: assert reset mid-stream with 2 entries queued -> immediately count=0, rf_we=0, hi_out=0, flag_z=1, flag_n=0, in_ready=1.
- Streaming: with rf_ready=1, push ADD result 0x0000_0005 to rd=3, then SUB result 0x0000_FFFF to rd=4 on consecutive cycles -> rf_we for 1 cycle each, writing (3,0x0005) then (4,0xFFFF). After the second retire, flag_n=1 and flag_z=0; hi_out stays 0.
- Multiply: push OP_MUL result 0x0001_E240 to rd=7 -> RF write (7,0xE240), hi_out=0x0001, flag_n=1.
- Backpressure and full: hold rf_ready=0 and push 3 entries -> in_ready drops after 2, count=2, head stable. Raise rf_ready -> in-order drain and the third entry is accepted the cycle after the first retire.
- Flags-only entry: with rf_ready=0, push we=0 and result 0 -> it retires in 1 cycle with rf_we=0 and flag_z=1.
- Wrap-around: 10 random back-to-back entries with random rf_ready -> the scoreboard matches order and data, count never exceeds DEPTH, and no entry is lost or duplicated.
